// File: rtl/regfile_dump_pkg.sv
// Shared register-file constants and the dump scanner state encoding.
// The register file uses the same address/data widths.
package regfile_dump_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 16;
  localparam int NUM_REGS   = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_W,
    SEND,
    CSUM,
    DONE
  } state_t;

endpackage

// File: rtl/regfile_dump.sv
// Register-file dump scanner: walks an address range on one read port and streams words (plus optional checksum).
// Latency: first word valid SETTLE+1 edges after start is sampled; one word per SETTLE+1 cycles with out_ready high.
// Backpressure: word, out_last and rf_addr hold while out_valid && !out_ready; nothing advances until the handshake.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int SETTLE   = 1,
  parameter int CHECKSUM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_remaining;
  logic [SET_W-1:0]    r_settle;
  logic [DATA_W-1:0]   r_sum;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_busy;
  logic                r_done;
  logic                w_hs;

  assign w_hs = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_settle    <= '0;
      r_sum       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr      <= first_addr;
            r_remaining <= (count == '0) ? CNT_W'(1 << ADDR_W) : count;
            r_sum       <= '0;
            r_settle    <= SET_W'(SETTLE);
            r_busy      <= 1'b1;
            r_state     <= SETTLE_W;
          end
        end
        SETTLE_W: begin
          r_settle <= r_settle - SET_W'(1);
          if (r_settle == SET_W'(1)) begin
            r_out_data  <= rf_data;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_remaining == CNT_W'(1)) && (CHECKSUM == 0);
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (w_hs) begin
            r_sum       <= r_sum + r_out_data;
            r_remaining <= r_remaining - CNT_W'(1);
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_remaining == CNT_W'(1)) begin
              if (CHECKSUM != 0) begin
                // Checksum word includes the word being accepted on this edge.
                r_out_data  <= r_sum + r_out_data;
                r_out_valid <= 1'b1;
                r_out_last  <= 1'b1;
                r_state     <= CSUM;
              end else begin
                r_done  <= 1'b1;
                r_state <= DONE;
              end
            end else begin
              r_addr   <= r_addr + ADDR_W'(1);
              r_settle <= SET_W'(SETTLE);
              r_state  <= SETTLE_W;
            end
          end
        end
        CSUM: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign rf_addr   = r_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: two instances (checksum on / off) share stimulus and a combinational register-file model.
// A transaction-level model predicts word stream, timing, busy and done; literal tables pin the model.
module tb_regfile_dump;
  import regfile_dump_pkg::*;

  localparam int SETTLE = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  first_addr = '0;
  logic [3:0]  count = '0;
  logic        out_ready = 1'b1;

  logic        busy_w [2];
  logic [2:0]  ra_w   [2];
  logic [15:0] rd_w   [2];
  logic        ov_w   [2];
  logic [15:0] od_w   [2];
  logic        ol_w   [2];
  logic        done_w [2];

  logic [15:0] mem [NUM_REGS];

  int errors = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  assign rd_w[0] = mem[ra_w[0]];
  assign rd_w[1] = mem[ra_w[1]];

  regfile_dump #(.SETTLE(SETTLE), .CHECKSUM(1)) u_cs (
    .clk(clk), .rst_n(rst_n), .start(start), .first_addr(first_addr), .count(count),
    .busy(busy_w[0]), .rf_addr(ra_w[0]), .rf_data(rd_w[0]), .out_valid(ov_w[0]),
    .out_ready(out_ready), .out_data(od_w[0]), .out_last(ol_w[0]), .done(done_w[0]));

  regfile_dump #(.SETTLE(SETTLE), .CHECKSUM(0)) u_nc (
    .clk(clk), .rst_n(rst_n), .start(start), .first_addr(first_addr), .count(count),
    .busy(busy_w[1]), .rf_addr(ra_w[1]), .rf_data(rd_w[1]), .out_valid(ov_w[1]),
    .out_ready(out_ready), .out_data(od_w[1]), .out_last(ol_w[1]), .done(done_w[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: expected word list per dump, progress and timing expectations.
  logic [15:0] exp_dat [2][16];
  int          exp_adr [2][16];
  int          n_exp [2], n_got [2], wait_ctr [2], done_cnt [2], log_n [2];
  bit          m_busy [2], done_due [2];
  logic [15:0] log_dat [2][64];
  int          log_adr [2][64];
  logic        log_last [2][64];
  int          cs_en [2] = '{1, 0};

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_exp[i] = 0; n_got[i] = 0; wait_ctr[i] = 0; done_cnt[i] = 0; log_n[i] = 0;
      m_busy[i] = 0; done_due[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk($sformatf("rst_busy%0d", i), busy_w[i], 0);
        chk($sformatf("rst_valid%0d", i), ov_w[i], 0);
        chk($sformatf("rst_last%0d", i), ol_w[i], 0);
        chk($sformatf("rst_done%0d", i), done_w[i], 0);
        chk($sformatf("rst_data%0d", i), od_w[i], 0);
        chk($sformatf("rst_addr%0d", i), ra_w[i], 0);
        m_busy[i] = 0; done_due[i] = 0; wait_ctr[i] = 0; n_exp[i] = 0; n_got[i] = 0;
      end else begin
        bit was_busy, exp_ov, nd;
        was_busy = m_busy[i];
        if (wait_ctr[i] > 0) wait_ctr[i]--;
        exp_ov = (wait_ctr[i] == 0) && (n_got[i] < n_exp[i]);
        chk($sformatf("busy%0d", i), busy_w[i], m_busy[i]);
        chk($sformatf("done%0d", i), done_w[i], done_due[i]);
        chk($sformatf("valid%0d", i), ov_w[i], exp_ov);
        if (done_w[i]) done_cnt[i]++;
        if (exp_ov && ov_w[i]) begin
          chk($sformatf("data%0d", i), od_w[i], exp_dat[i][n_got[i]]);
          chk($sformatf("last%0d", i), ol_w[i], (n_got[i] == n_exp[i] - 1));
          if (exp_adr[i][n_got[i]] >= 0)
            chk($sformatf("rf_addr%0d", i), ra_w[i], exp_adr[i][n_got[i]]);
        end
        nd = 0;
        if (exp_ov && out_ready) begin
          if (log_n[i] < 64) begin
            log_dat[i][log_n[i]] = od_w[i];
            log_adr[i][log_n[i]] = ra_w[i];
            log_last[i][log_n[i]] = ol_w[i];
            log_n[i]++;
          end
          n_got[i]++;
          if (n_got[i] == n_exp[i]) nd = 1;
          else if (exp_adr[i][n_got[i]] >= 0) wait_ctr[i] = SETTLE + 1;
          else wait_ctr[i] = 1;
        end
        if (done_due[i]) m_busy[i] = 0;
        if (!was_busy && start) begin
          int n, a;
          logic [15:0] s;
          n = (count == 0) ? NUM_REGS : int'(count);
          s = 16'h0;
          for (int k = 0; k < n; k++) begin
            a = (int'(first_addr) + k) % NUM_REGS;
            exp_dat[i][k] = mem[a];
            exp_adr[i][k] = a;
            s = s + mem[a];
          end
          if (cs_en[i] != 0) begin
            exp_dat[i][n] = s;
            exp_adr[i][n] = -1;
            n++;
          end
          n_exp[i] = n; n_got[i] = 0;
          m_busy[i] = 1;
          wait_ctr[i] = SETTLE + 1;
        end
        done_due[i] = nd;
      end
    end
  end

  task automatic do_start(input logic [2:0] fa, input logic [3:0] cnt);
    @(posedge clk); #1;
    first_addr = fa; count = cnt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((busy_w[0] || busy_w[1]) && c < 400) begin
      @(posedge clk); #2; c++;
    end
    chk("idle_reached", {31'd0, busy_w[0] | busy_w[1]}, 0);
  endtask

  task automatic wait_log(input int i, input int n);
    int c = 0;
    while (log_n[i] < n && c < 400) begin
      @(posedge clk); #2; c++;
    end
    chk("log_reached", (log_n[i] >= n), 1);
  endtask

  task automatic wait_valid0();
    int c = 0;
    while (!ov_w[0] && c < 400) begin
      @(posedge clk); #2; c++;
    end
    chk("valid_reached", ov_w[0], 1);
  endtask

  task automatic chk_words(input string nm, input int i, input int base, input logic [15:0] e[$]);
    chk({nm, "_len"}, log_n[i] - base, e.size());
    for (int k = 0; k < e.size(); k++)
      if (base + k < log_n[i]) chk($sformatf("%s_w%0d", nm, k), log_dat[i][base + k], e[k]);
    if (log_n[i] > base) chk({nm, "_lastflag"}, log_last[i][log_n[i] - 1], 1);
  endtask

  initial begin
    int b0, b1, d0, d1;
    logic [15:0] ew[$];
    for (int j = 0; j < NUM_REGS; j++) mem[j] = 16'(j * 16'h1111);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full dump: 0x0000..0x7777 then checksum 28*0x1111 = 0x1DDDC -> 0xDDDC.
    b0 = log_n[0]; b1 = log_n[1]; d0 = done_cnt[0]; d1 = done_cnt[1];
    do_start(3'd0, 4'd0);
    @(negedge clk); chk("lat_valid_low", ov_w[0], 0);
    @(negedge clk); chk("lat_valid_high", ov_w[0], 1);
    wait_idle();
    ew = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'hDDDC};
    chk_words("full_cs", 0, b0, ew);
    ew = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
    chk_words("full_nc", 1, b1, ew);
    chk("full_done_cs", done_cnt[0] - d0, 1);
    chk("full_done_nc", done_cnt[1] - d1, 1);

    // Wrap-around from 6.
    b0 = log_n[0];
    do_start(3'd6, 4'd4);
    wait_idle();
    ew = '{16'h6666, 16'h7777, 16'h0000, 16'h1111, 16'hEEEE};
    chk_words("wrap", 0, b0, ew);
    chk("wrap_a0", log_adr[0][b0], 6);
    chk("wrap_a1", log_adr[0][b0 + 1], 7);
    chk("wrap_a2", log_adr[0][b0 + 2], 0);
    chk("wrap_a3", log_adr[0][b0 + 3], 1);

    // Backpressure on the 2nd word; register contents change under the held word.
    b0 = log_n[0]; b1 = log_n[1]; d0 = done_cnt[0];
    do_start(3'd1, 4'd3);
    wait_log(0, b0 + 1);
    out_ready = 1'b0;
    wait_valid0();
    mem[2] = 16'hBEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", ov_w[0], 1);
      chk("bp_data", od_w[0], 16'h2222);
      chk("bp_addr", ra_w[0], 2);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();
    mem[2] = 16'h2222;
    ew = '{16'h1111, 16'h2222, 16'h3333, 16'h6666};
    chk_words("bp_cs", 0, b0, ew);
    ew = '{16'h1111, 16'h2222, 16'h3333};
    chk_words("bp_nc", 1, b1, ew);
    chk("bp_done", done_cnt[0] - d0, 1);

    // Single register.
    b0 = log_n[0]; b1 = log_n[1]; d1 = done_cnt[1];
    do_start(3'd3, 4'd1);
    wait_idle();
    ew = '{16'h3333};
    chk_words("single_nc", 1, b1, ew);
    ew = '{16'h3333, 16'h3333};
    chk_words("single_cs", 0, b0, ew);
    chk("single_done", done_cnt[1] - d1, 1);

    // Start pulse while busy is ignored.
    b0 = log_n[0]; b1 = log_n[1]; d0 = done_cnt[0];
    do_start(3'd0, 4'd3);
    repeat (2) @(posedge clk);
    #1 first_addr = 3'd5; count = 4'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    ew = '{16'h0000, 16'h1111, 16'h2222, 16'h3333};
    chk_words("busy_cs", 0, b0, ew);
    ew = '{16'h0000, 16'h1111, 16'h2222};
    chk_words("busy_nc", 1, b1, ew);
    chk("busy_done", done_cnt[0] - d0, 1);

    // Reset mid-dump while a word is held, then a fresh dump.
    b0 = log_n[0];
    do_start(3'd0, 4'd5);
    wait_log(0, b0 + 1);
    out_ready = 1'b0;
    wait_valid0();
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", ov_w[0], 0);
    chk("arst_busy", busy_w[0], 0);
    chk("arst_data", od_w[0], 0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    b0 = log_n[0]; d0 = done_cnt[0];
    do_start(3'd0, 4'd2);
    wait_idle();
    ew = '{16'h0000, 16'h1111, 16'h1111};
    chk_words("post_rst", 0, b0, ew);
    chk("post_rst_done", done_cnt[0] - d0, 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
